// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment scan controller.
package seg_pkg;

  typedef enum logic [1:0] {LOAD, SHOW, BLANK} seg_state_e;

  localparam logic [3:0] BCD_BLANK = 4'hF;
  localparam logic [7:0] SEG_OFF   = 8'hFF;

  function automatic int max2(int a, int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/seg_scan_controller_dec.sv
// BcdDecoder: BCD nibble + dp request to active-low {a,b,c,d,e,f,g,dp}.
module BcdDecoder (
  input  logic [3:0] bcd_i,
  input  logic       dp_i,
  output logic [7:0] seg_n_o
);

  logic [6:0] abcdefg_n;

  always_comb begin
    abcdefg_n = 7'b1111111;
    case (bcd_i)
      4'd0:    abcdefg_n = 7'b0000001;
      4'd1:    abcdefg_n = 7'b1001111;
      4'd2:    abcdefg_n = 7'b0010010;
      4'd3:    abcdefg_n = 7'b0000110;
      4'd4:    abcdefg_n = 7'b1001100;
      4'd5:    abcdefg_n = 7'b0100100;
      4'd6:    abcdefg_n = 7'b0100000;
      4'd7:    abcdefg_n = 7'b0001111;
      4'd8:    abcdefg_n = 7'b0000000;
      4'd9:    abcdefg_n = 7'b0000100;
      default: abcdefg_n = 7'b1111111;  // A-F stay dark
    endcase
  end

  assign seg_n_o = {abcdefg_n, ~dp_i};

endmodule

// File: rtl/seg_scan_controller.sv
// Multiplexed scan controller for a common-anode seven-segment display.
// Define SEG_LZ_BLANK_EN to blank leading zeros when the frame is loaded.
module seg_scan_controller
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 8,
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    freeze,
  output logic [7:0]              seg_n,
  output logic [NUM_DIGITS-1:0]   sel_n,
  output logic                    frame_tick
);

  localparam int CNT_W = $clog2(max2(SCAN_DIV, BLANK_CYCLES) + 1);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] SHOW_LD  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LD = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  seg_state_e state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [NUM_DIGITS-1:0][3:0] bcd_q, bcd_d, bcd_load;
  logic [NUM_DIGITS-1:0] dp_q, dp_d, en_q, en_d;
  logic [7:0] seg_n_q, seg_n_d, dec_seg_n;
  logic [NUM_DIGITS-1:0] sel_n_q, sel_n_d;
  logic step;

  // Nibbles as they will be stored at LOAD
`ifdef SEG_LZ_BLANK_EN
  logic lead;
  always_comb begin
    bcd_load = bcd_in;
    lead     = 1'b1;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      if (lead && bcd_load[i] == 4'h0) bcd_load[i] = BCD_BLANK;
      else lead = 1'b0;
    end
  end
`else
  always_comb bcd_load = bcd_in;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    dp_d    = dp_q;
    en_d    = en_q;
    step    = 1'b0;
    case (state_q)
      LOAD: begin
        state_d = SHOW;
        idx_d   = '0;
        cnt_d   = SHOW_LD;
        if (!freeze) begin
          bcd_d = bcd_load;
          dp_d  = dp_in;
          en_d  = digit_en;
        end
      end
      SHOW: begin
        if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
        else if (BLANK_CYCLES > 0) begin
          state_d = BLANK;
          cnt_d   = BLANK_LD;
        end else step = 1'b1;
      end
      BLANK: begin
        if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
        else step = 1'b1;
      end
      default: state_d = LOAD;
    endcase
    // The index only wraps by passing through LOAD
    if (step) begin
      if (idx_q == LAST_IDX) begin
        state_d = LOAD;
        cnt_d   = '0;
      end else begin
        state_d = SHOW;
        idx_d   = idx_q + IDX_W'(1);
        cnt_d   = SHOW_LD;
      end
    end
  end

  // Decode from next-state values so select and segments flip on one edge
  BcdDecoder u_dec (
    .bcd_i   (bcd_d[idx_d]),
    .dp_i    (dp_d[idx_d]),
    .seg_n_o (dec_seg_n)
  );

  always_comb begin
    seg_n_d = SEG_OFF;
    sel_n_d = '1;
    if (state_d == SHOW) begin
      for (int i = 0; i < NUM_DIGITS; i++) sel_n_d[i] = (idx_d != IDX_W'(i));
      if (en_d[idx_d]) seg_n_d = dec_seg_n;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LOAD;
      idx_q   <= '0;
      cnt_q   <= '0;
      bcd_q   <= {NUM_DIGITS{BCD_BLANK}};
      dp_q    <= '0;
      en_q    <= '0;
      seg_n_q <= SEG_OFF;
      sel_n_q <= '1;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      dp_q    <= dp_d;
      en_q    <= en_d;
      seg_n_q <= seg_n_d;
      sel_n_q <= sel_n_d;
    end
  end

  assign seg_n      = seg_n_q;
  assign sel_n      = sel_n_q;
  assign frame_tick = (state_q == LOAD) && !rst;

endmodule
